// File: rtl/intersection_pkg.sv
// Shared state codes for the intersection sequencer.
// Phase codes are also exported on the debug port.
package intersection_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    WALK      = 3'd6,
    PED_CLR   = 3'd7
  } state_t;

endpackage

// File: rtl/intersection_sequencer_phase_timer.sv
// Phase timer: counts cycles spent in the current phase.
// Saturates at all-ones so long NS rests never wrap.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // saturating up-counter with synchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (cnt != CNT_MAX)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/intersection_sequencer.sv
// Two-approach intersection sequencer with ped crossing.
// Moore lamp outputs decoded from the phase register.
module intersection_sequencer
  import intersection_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int T_GREEN_MIN = 8,
  parameter int T_GREEN_MAX = 20,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ped_req,
  input  logic       car_ew,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] GMIN_L = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_L = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_L  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_L   = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] WALK_L = CNT_W'(T_WALK - 1);

  state_t           state;
  state_t           state_d;
  logic             ped_pend;
  logic             clr;
  logic [CNT_W-1:0] cnt;

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clr    (clr),
    .cnt    (cnt)
  );

  // timer restarts on every phase change
  assign clr   = (state_d != state);
  assign phase = state;

  // phase register; reset lands in ped clearance
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= PED_CLR;
    else
      state <= state_d;
  end

  // ped latch; requests during walk are dropped
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      ped_pend <= 1'b0;
    else if (state == WALK)
      ped_pend <= 1'b0;
    else
      ped_pend <= ped_pend | ped_req;
  end

  // next-phase logic
  always_comb begin
    state_d = state;
    unique case (state)
      NS_GREEN: begin
        if (cnt >= GMIN_L && (car_ew || ped_pend))
          state_d = NS_YELLOW;
      end
      NS_YELLOW: begin
        if (cnt == YEL_L)
          state_d = ALLRED_A;
      end
      ALLRED_A: begin
        if (cnt == AR_L) begin
          if (car_ew)
            state_d = EW_GREEN;
          else if (ped_pend)
            state_d = WALK;
          else
            state_d = NS_GREEN;
        end
      end
      EW_GREEN: begin
        if ((cnt >= GMIN_L && !car_ew) || cnt == GMAX_L)
          state_d = EW_YELLOW;
      end
      EW_YELLOW: begin
        if (cnt == YEL_L)
          state_d = ALLRED_B;
      end
      ALLRED_B: begin
        if (cnt == AR_L)
          state_d = ped_pend ? WALK : NS_GREEN;
      end
      WALK: begin
        if (cnt == WALK_L)
          state_d = PED_CLR;
      end
      PED_CLR: begin
        if (cnt == AR_L)
          state_d = NS_GREEN;
      end
      default: state_d = PED_CLR;
    endcase
  end

  // lamp decode; red on both approaches by default
  always_comb begin
    ns_g = 1'b0;
    ns_y = 1'b0;
    ns_r = 1'b1;
    ew_g = 1'b0;
    ew_y = 1'b0;
    ew_r = 1'b1;
    walk = 1'b0;
    unique case (1'b1)
      (state == NS_GREEN):  begin ns_g = 1'b1; ns_r = 1'b0; end
      (state == NS_YELLOW): begin ns_y = 1'b1; ns_r = 1'b0; end
      (state == EW_GREEN):  begin ew_g = 1'b1; ew_r = 1'b0; end
      (state == EW_YELLOW): begin ew_y = 1'b1; ew_r = 1'b0; end
      (state == WALK):      walk = 1'b1;
      default: ;
    endcase
  end

endmodule
